gmii_tx_scheduler: RTL

//  Two-requester GMII transmit scheduler feeding the PCS transmit side (TXD/TX_EN/TX_ER on GTX_CLK).

---
 rtl/gmii_tx_scheduler_pkg.sv | 33 +++
 rtl/gmii_tx_scheduler_rr_arbiter2.sv | 50 +++++
 rtl/gmii_tx_scheduler.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/gmii_tx_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gmii_tx_scheduler_pkg
// Purpose  : Shared encodings for the GMII transmit scheduler: PCS xmit
//            state codes, frame delimiter bytes, counter width and the
//            scheduler state enumeration.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package gmii_tx_scheduler_pkg;

  // PCS xmit state encodings (one-hot as presented by the PCS)
  localparam logic [2:0] XMIT_CONFIGURATION = 3'b001;
  localparam logic [2:0] XMIT_IDLE          = 3'b010;
  localparam logic [2:0] XMIT_DATA          = 3'b100;

  // Frame delimiter bytes
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  // Shared counter width (preamble, payload byte and gap counting)
  localparam int CNT_W = 11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SFD      = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_IPG      = 3'd4
  } sched_state_e;

endpackage : gmii_tx_scheduler_pkg
`default_nettype wire

// File: rtl/gmii_tx_scheduler_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : gmii_tx_scheduler_rr_arbiter2
// Purpose  : Two-way round-robin arbiter. Grant is combinational from the
//            request vector and the priority pointer; the pointer moves to
//            the other requester whenever a grant is taken (update=1).
// Ports    : clk    in  1  clock
//            rst_n  in  1  asynchronous active-low reset (pointer -> req0)
//            req    in  2  request vector
//            update in  1  grant is being accepted this cycle
//            gnt    out 2  one-hot grant (zero when no request)
// Revision : 1.0 - initial release
// ============================================================================
module gmii_tx_scheduler_rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  // ptr_q = 0 favours req[0], 1 favours req[1]
  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr_q ? 2'b10 : 2'b01;
    end
  end

  // After granting requester 0 the pointer favours 1, and vice versa.
  always_comb begin
    ptr_d = ptr_q;
    if (update && (gnt != 2'b00)) begin
      ptr_d = gnt[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule : gmii_tx_scheduler_rr_arbiter2
`default_nettype wire

// File: rtl/gmii_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : gmii_tx_scheduler
// Purpose  : Two-requester GMII transmit scheduler. Round-robin selects a
//            frame source, frames it as preamble + SFD + payload, enforces
//            the inter-packet gap and only starts frames while the PCS is in
//            xmit=DATA.
// Ports    : GTX_CLK          in   1  transmit clock (rising edge)
//            mr_main_reset_n  in   1  asynchronous active-low reset
//            xmit             in   3  PCS xmit state (CONFIG/IDLE/DATA)
//            req0/req1        in   1  requester has a frame pending
//            data0/data1      in   8  payload byte from requester
//            valid0/valid1    in   1  data_x valid
//            last0/last1      in   1  data_x is final payload byte
//            rd0/rd1          out  1  byte consumed this cycle (comb)
//            gnt              out  2  one-hot grant (registered)
//            TXD              out  8  GMII transmit data (registered)
//            TX_EN            out  1  GMII transmit enable (registered)
//            TX_ER            out  1  GMII transmit error (registered)
//            busy             out  1  scheduler not idle
// Revision : 1.0 - initial release
// ============================================================================
module gmii_tx_scheduler
  import gmii_tx_scheduler_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int IPG_LEN      = 12,
  parameter int MAX_LEN      = 1518
) (
  input  logic       GTX_CLK,
  input  logic       mr_main_reset_n,
  input  logic [2:0] xmit,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last0,
  input  logic       last1,
  output logic       rd0,
  output logic       rd1,
  output logic [1:0] gnt,
  output logic [7:0] TXD,
  output logic       TX_EN,
  output logic       TX_ER,
  output logic       busy
);

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
  // The IDLE cycle that follows IPG also drives TX_EN=0 and is the cycle on
  // which the next grant can be taken, so the IPG state itself lasts one
  // cycle less than the gap that appears on the wire.
  localparam logic [CNT_W-1:0] IPG_LAST = CNT_W'(IPG_LEN - 2);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_LEN);

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [1:0]       gnt_q,   gnt_d;
  logic [7:0]       txd_q,   txd_d;
  logic             tx_en_q, tx_en_d;
  logic             tx_er_q, tx_er_d;

  logic [1:0] arb_gnt;
  logic       start;
  logic       sel_valid;
  logic       sel_last;
  logic [7:0] sel_data;
  logic       at_max;
  logic       take;

  // A frame may only begin from IDLE while the PCS is in DATA.
  assign start = (state_q == ST_IDLE) && (xmit == XMIT_DATA) && (req0 || req1);

  gmii_tx_scheduler_rr_arbiter2 u_arb (
    .clk    (GTX_CLK),
    .rst_n  (mr_main_reset_n),
    .req    ({req1, req0}),
    .update (start),
    .gnt    (arb_gnt)
  );

  // gnt_q is one-hot during a frame, so a single bit selects the source.
  assign sel_valid = gnt_q[1] ? valid1 : valid0;
  assign sel_last  = gnt_q[1] ? last1  : last0;
  assign sel_data  = gnt_q[1] ? data1  : data0;

  // Once MAX_LEN bytes have gone out the next byte is refused, not consumed.
  assign at_max = (cnt_q == MAX_CNT);
  assign take   = (state_q == ST_PAYLOAD) && !at_max && sel_valid;

  assign rd0  = take & gnt_q[0];
  assign rd1  = take & gnt_q[1];
  assign busy = (state_q != ST_IDLE);

  assign gnt   = gnt_q;
  assign TXD   = txd_q;
  assign TX_EN = tx_en_q;
  assign TX_ER = tx_er_q;

  // Next-state and output logic. The GMII outputs are a function of the
  // current state, so they appear on the wire one cycle behind the state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    txd_d   = 8'h00;
    tx_en_d = 1'b0;
    tx_er_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = ST_PREAMBLE;
          gnt_d   = arb_gnt;
        end
      end

      ST_PREAMBLE: begin
        tx_en_d = 1'b1;
        txd_d   = PREAMBLE_BYTE;
        if (cnt_q == PRE_LAST) begin
          state_d = ST_SFD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_SFD: begin
        tx_en_d = 1'b1;
        txd_d   = SFD_BYTE;
        state_d = ST_PAYLOAD;
        cnt_d   = '0;
      end

      ST_PAYLOAD: begin
        tx_en_d = 1'b1;
        if (take) begin
          txd_d = sel_data;
          cnt_d = cnt_q + 1'b1;
          if (sel_last) begin
            state_d = ST_IPG;
            gnt_d   = 2'b00;
            cnt_d   = '0;
          end
        end else begin
          // Underrun or over-length frame: flag one error cycle and abort.
          tx_er_d = 1'b1;
          state_d = ST_IPG;
          gnt_d   = 2'b00;
          cnt_d   = '0;
        end
      end

      ST_IPG: begin
        if (cnt_q == IPG_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge GTX_CLK or negedge mr_main_reset_n) begin
    if (!mr_main_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gnt_q   <= 2'b00;
      txd_q   <= 8'h00;
      tx_en_q <= 1'b0;
      tx_er_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      txd_q   <= txd_d;
      tx_en_q <= tx_en_d;
      tx_er_q <= tx_er_d;
    end
  end

endmodule : gmii_tx_scheduler
`default_nettype wire
